mem_arbiter: RTL and testbench

- Sequential arbiter between the CPU fetch/request side and the single-ported RAM.
- Accepts an instruction read request, and a data read or data write request from the request unit's dmemREN/dmemWEN outputs.
- Serialises these onto one RAM port, then returns one-cycle ihit/dhit pulses with the load data.
- Those pulses are the ihit/dhit that drive PC enable and clear the data-request latches upstream.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Serialises instruction and data requests onto one single-ported RAM and
// returns one-cycle ihit/dhit pulses, with a per-access timeout that raises a sticky err.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ack,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, IACC, DACC, IRESP, DRESP} state_t;

  localparam logic [DATA_W-1:0] LP_BAD   = DATA_W'(32'hBAD1BAD1);
  localparam logic [7:0]        LP_LIMIT = 8'(TIMEOUT - 1);

  state_t              r_state, w_next;
  logic                r_last_d;
  logic [7:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wr;
  logic [DATA_W-1:0]   r_iload, r_dload;
  logic                r_err;
  logic                w_dreq, w_grant_i, w_grant_d, w_tmo;

  // Instruction wins a tie only when data was served last, so neither side starves.
  always_comb begin
    w_dreq    = dREN | dWEN;
    w_grant_i = iREN & (~w_dreq | r_last_d);
    w_grant_d = w_dreq & ~w_grant_i;
    w_tmo     = (r_cnt == LP_LIMIT);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    ihit     = 1'b0;
    dhit     = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_i)      w_next = IACC;
        else if (w_grant_d) w_next = DACC;
      end
      IACC: begin
        ramREN   = 1'b1;
        ramaddr  = r_addr;
        ramstore = r_wdata;
        if (ram_ack || w_tmo) w_next = IRESP;
      end
      DACC: begin
        ramREN   = ~r_wr;
        ramWEN   = r_wr;
        ramaddr  = r_addr;
        ramstore = r_wdata;
        if (ram_ack || w_tmo) w_next = DRESP;
      end
      IRESP: begin
        ihit   = 1'b1;
        w_next = IDLE;
      end
      DRESP: begin
        dhit   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_last_d <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
      r_iload  <= '0;
      r_dload  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_addr   <= iaddr;
            r_wdata  <= dstore;
            r_wr     <= 1'b0;
            r_last_d <= 1'b0;
            r_cnt    <= '0;
          end else if (w_grant_d) begin
            r_addr   <= daddr;
            r_wdata  <= dstore;
            r_wr     <= dWEN;
            r_last_d <= 1'b1;
            r_cnt    <= '0;
          end
        end
        IACC: begin
          if (ram_ack) begin
            r_iload <= ramload;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_iload <= LP_BAD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DACC: begin
          if (ram_ack) begin
            if (!r_wr) r_dload <= ramload;
          end else if (w_tmo) begin
            r_err <= 1'b1;
            if (!r_wr) r_dload <= LP_BAD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign iload = r_iload;
  assign dload = r_dload;
  assign err   = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of transactions driven through a scoreboard,
// plus a hand-written mid-access reset sequence.
module tb_mem_arbiter;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN, ram_ack;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit), .iload(iload),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ram_ack(ram_ack), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iren, dren, dwen;
    logic [31:0] iaddr, daddr, dstore, ramload;
    int          waits;
    logic        ack;
    logic        exp_d;
    logic        exp_wen;
    logic [31:0] exp_addr, exp_iload, exp_dload;
    logic        exp_err;
  } vec_t;

  vec_t tbl[9];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST && ihit && dhit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL hit_excl: ihit and dhit both high at %0t", $time);
    end
  end

  task automatic drop_reqs();
    iREN = 0; dREN = 0; dWEN = 0; ram_ack = 0;
  endtask

  // One transaction: drive in IDLE, hold through the ACC cycles, score at the hit.
  task automatic do_txn(input vec_t v);
    vec_t e;
    @(negedge CLK);
    iREN = v.iren; dREN = v.dren; dWEN = v.dwen;
    iaddr = v.iaddr; daddr = v.daddr; dstore = v.dstore; ram_ack = 0;
    sb.push_back(v);
    @(posedge CLK); #1;
    for (int k = 0; k <= v.waits; k++) begin
      chk("acc_strobes", {28'd0, ramREN, ramWEN, ihit, dhit},
          {28'd0, ~v.exp_wen, v.exp_wen, 1'b0, 1'b0});
      chk("acc_addr", ramaddr, v.exp_addr);
      if (v.exp_wen) chk("acc_store", ramstore, v.dstore);
      ram_ack = v.ack && (k == v.waits);
      ramload = v.ramload;
      @(posedge CLK); #1;
    end
    drop_reqs();
    chk("resp_hit", {30'd0, ihit, dhit}, {30'd0, ~v.exp_d, v.exp_d});
    chk("resp_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_empty: hit with no pending expectation at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk("iload", iload, e.exp_iload);
      chk("dload", dload, e.exp_dload);
      chk("err", {31'd0, err}, {31'd0, e.exp_err});
    end
    @(posedge CLK); #1;
    chk("idle_nohit", {30'd0, ihit, dhit}, 32'd0);
  endtask

  initial begin
    vec_t v;
    nRST = 0; drop_reqs();
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    #1;
    chk("rst_outs", {27'd0, ihit, dhit, ramREN, ramWEN, err}, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    @(negedge CLK); nRST = 1;

    //            iren dren dwen iaddr      daddr      dstore        ramload       w  ack d  wen addr       iload         dload         err
    tbl[0] = '{1, 0, 0, 32'h100, 32'h0,   32'h0,        32'h8C220004, 0, 1, 0, 0, 32'h100, 32'h8C220004, 32'h0,        0};
    tbl[1] = '{1, 1, 0, 32'h104, 32'h200, 32'h0,        32'h11112222, 1, 1, 1, 0, 32'h200, 32'h8C220004, 32'h11112222, 0};
    tbl[2] = '{1, 1, 0, 32'h104, 32'h200, 32'h0,        32'h24420008, 0, 1, 0, 0, 32'h104, 32'h24420008, 32'h11112222, 0};
    tbl[3] = '{0, 1, 1, 32'h0,   32'h40,  32'hDEADBEEF, 32'h99999999, 3, 1, 1, 1, 32'h40,  32'h24420008, 32'h11112222, 0};
    tbl[4] = '{0, 1, 0, 32'h0,   32'h44,  32'h0,        32'hCAFEF00D, 2, 1, 1, 0, 32'h44,  32'h24420008, 32'hCAFEF00D, 0};
    tbl[5] = '{1, 0, 1, 32'h108, 32'h48,  32'h12345678, 32'h0000ABCD, 0, 1, 0, 0, 32'h108, 32'h0000ABCD, 32'hCAFEF00D, 0};
    tbl[6] = '{1, 0, 1, 32'h108, 32'h48,  32'h12345678, 32'h0,        1, 1, 1, 1, 32'h48,  32'h0000ABCD, 32'hCAFEF00D, 0};
    tbl[7] = '{0, 1, 0, 32'h0,   32'h80,  32'h0,        32'h0,        3, 0, 1, 0, 32'h80,  32'h0000ABCD, 32'hBAD1BAD1, 1};
    tbl[8] = '{1, 0, 0, 32'h10C, 32'h0,   32'h0,        32'h3C010001, 0, 1, 0, 0, 32'h10C, 32'h3C010001, 32'hBAD1BAD1, 1};

    for (int i = 0; i < 9; i++) do_txn(tbl[i]);

    // Asynchronous reset in the middle of a stalled data write.
    @(negedge CLK);
    dWEN = 1; daddr = 32'h90; dstore = 32'h55; ram_ack = 0;
    @(posedge CLK); #1;
    chk("mid_wen", {31'd0, ramWEN}, 32'd1);
    @(posedge CLK); #2;
    nRST = 0;
    #1;
    chk("mid_rst_outs", {27'd0, ihit, dhit, ramREN, ramWEN, err}, 32'd0);
    chk("mid_rst_addr", ramaddr, 32'd0);
    chk("mid_rst_iload", iload, 32'd0);
    chk("mid_rst_dload", dload, 32'd0);
    drop_reqs();
    @(negedge CLK); nRST = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      chk("post_rst_nohit", {28'd0, ihit, dhit, ramREN, ramWEN}, 32'd0);
    end

    // After reset last_d is 0 again, so a tie goes to data first.
    v = '{1, 1, 0, 32'h300, 32'h204, 32'h0, 32'h00000077, 0, 1, 1, 0, 32'h204, 32'h0, 32'h00000077, 0};
    do_txn(v);
    v = '{1, 1, 0, 32'h300, 32'h204, 32'h0, 32'h00000088, 0, 1, 0, 0, 32'h300, 32'h00000088, 32'h00000077, 0};
    do_txn(v);

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_leftover: %0d expectations never matched", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
